rx_frame_assembler: RTL and testbench
=====================================

// Module: rx_frame_assembler
// PURPOSE
//  Consumer stage directly downstream of the PPM Decoder. Takes decoded N_PKT-bit bytes, hunts for a SYNC byte,
//  collects PAYLOAD bytes plus an 8-bit additive checksum, then presents the whole frame on a valid/ready port.
//  Also keeps saturating good/bad frame counters for link-quality display on the board.
// PARAMETERS
//  N_PKT    8        bits per decoded byte (matches Decoder N_PKT)
//  PAYLOAD  4        payload bytes per frame (>=1)
//  SYNC     8'hA5    frame start marker, N_PKT bits wide
//  TIMEOUT  1000000  max clk cycles between accepted bytes inside a frame
//  TIMER_W  24       inter-byte timer width; must hold TIMEOUT
//  CNT_W    16       width of the good/bad frame counters
// PORTS
//  clk          in   1              system clock
//  rst_n        in   1              asynchronous, active-low reset
//  dec_data     in   N_PKT          byte from Decoder
//  dec_avail    in   1              Decoder has a byte; held until consumed
//  dec_error    in   1              Decoder packet-error pulse
//  dec_read     out  1              consume strobe; byte transfers when dec_avail & dec_read
//  frame_data   out  PAYLOAD*N_PKT  assembled payload; byte 0 at bits [N_PKT-1:0]
//  frame_valid  out  1              frame_data holds a checked frame
//  frame_ready  in   1              sink accepts frame when frame_valid & frame_ready
//  good_ct      out  CNT_W          frames passed checksum (saturating)
//  bad_ct       out  CNT_W          frames aborted/failed (saturating)
// BEHAVIOUR
//  Reset: state HUNT, frame_valid=0, frame_data=0, good_ct=bad_ct=0, idx=0, sum=0, timer=0.
//  dec_read = (state != HOLD), combinational from state (1 while in reset).
//  "accept" = dec_avail & dec_read. All state updates on posedge clk.
//  HUNT: on accept, byte==SYNC -> PAYLOAD (idx=0, sum=0, timer=0); other bytes dropped. dec_error ignored.
//  PAYLOAD: on accept, write byte to slot idx, sum=sum+byte mod 2^N_PKT, timer=0;
//    idx==PAYLOAD-1 -> CHECK, else idx++. A SYNC value here is ordinary data.
//  CHECK: on accept, byte==sum -> HOLD, good_ct++; else -> HUNT, bad_ct++.
//  HOLD: frame_valid=1, frame_data stable, no bytes consumed; frame_valid & frame_ready -> HUNT, frame_valid=0 next cycle.
//  Latency: checksum byte accepted at edge t -> frame_valid=1 after edge t; ready seen at edge u -> valid=0 after u.
//  frame_data updates only while in PAYLOAD; retains last frame after HOLD exits.
//  Abort (PAYLOAD/CHECK only): dec_error=1, or timer reaches TIMEOUT with no accept -> HUNT, bad_ct++, idx=0.
//  Timer: increments each cycle in PAYLOAD/CHECK without accept; cleared on accept and in HUNT/HOLD.
//  Simultaneous dec_error & accept in PAYLOAD/CHECK: error wins; byte consumed and discarded; single bad_ct++.
//  Simultaneous timeout & accept: accept wins, timer cleared.
//  Counters saturate at 2^CNT_W-1; never wrap. At most one increment per cycle.
//  rst_n low mid-frame: immediate return to reset values; partial frame lost, not counted.
// TESTING
//  1 Good frame A5,01,02,03,04,0A -> frame_valid=1 one cycle after 0A accepted, frame_data=32'h04030201, good_ct=1.
//  2 Bad checksum A5,01,02,03,04,0B -> no frame_valid, bad_ct=1; following good frame still delivered, good_ct=1.
//  3 Garbage 00,FF,3C then good frame; also payload byte A5 (A5,A5,00,00,00,A5) -> garbage dropped, both frames valid.
//  4 frame_ready=0 for 20 cycles with dec_avail=1 -> dec_read=0, frame_data stable; ready=1 -> HUNT next cycle, dec_read=1.
//  5 dec_error after 2 payload bytes -> bad_ct=1, HUNT; TIMEOUT=16, stall after 2 bytes -> abort at 16th idle cycle, bad_ct=2.
//  6 rst_n low after 3 payload bytes -> all outputs reset values; CNT_W=2 with 5 bad frames -> bad_ct=3 (saturated).

Source files
------------

// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler: hunts for a SYNC byte in the decoded byte stream, gathers
// PAYLOAD bytes plus an additive checksum, and offers each good frame on a
// valid/ready port. Saturating good/bad frame counters track link quality.
module rx_frame_assembler #(
  parameter int              N_PKT   = 8,
  parameter int              PAYLOAD = 4,
  parameter logic [N_PKT-1:0] SYNC   = 8'hA5,
  parameter int              TIMEOUT = 1000000,
  parameter int              TIMER_W = 24,
  parameter int              CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PKT-1:0]           dec_data,
  input  logic                       dec_avail,
  input  logic                       dec_error,
  output logic                       dec_read,
  output logic [PAYLOAD*N_PKT-1:0]   frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [CNT_W-1:0]           good_ct,
  output logic [CNT_W-1:0]           bad_ct
);

  localparam int IDX_W = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1;

  typedef enum logic [1:0] {
    S_HUNT,
    S_PAYLOAD,
    S_CHECK,
    S_HOLD
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [N_PKT-1:0]   sum;
  logic [TIMER_W-1:0] timer;
  logic               accept;
  logic               in_frame;
  logic               last_slot;
  logic               timeout;
  logic               abort;
  logic               write_en;
  logic               good_inc;
  logic               bad_inc;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign dec_read    = (state != S_HOLD);
  assign frame_valid = (state == S_HOLD);
  assign accept      = dec_avail & dec_read;
  assign in_frame    = (state == S_PAYLOAD) || (state == S_CHECK);
  assign last_slot   = (idx == IDX_W'(PAYLOAD - 1));
  // The idle cycle that would bring the timer up to TIMEOUT is the abort cycle;
  // an accept on that same cycle takes priority.
  assign timeout     = (timer == TIMER_W'(TIMEOUT - 1)) && !accept;
  // A decoder error discards the frame even if a byte is consumed with it.
  assign abort       = in_frame && (dec_error || timeout);
  assign write_en    = (state == S_PAYLOAD) && accept && !dec_error;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_nxt;
  end

  // Next-state decode and counter increment requests.
  always_comb begin
    state_nxt = state;
    good_inc  = 1'b0;
    bad_inc   = 1'b0;
    case (state)
      S_HUNT: begin
        if (accept && (dec_data == SYNC)) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (abort) begin
          state_nxt = S_HUNT;
          bad_inc   = 1'b1;
        end else if (accept && last_slot) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_nxt = S_HUNT;
          bad_inc   = 1'b1;
        end else if (accept) begin
          if (dec_data == sum) begin
            state_nxt = S_HOLD;
            good_inc  = 1'b1;
          end else begin
            state_nxt = S_HUNT;
            bad_inc   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (frame_ready) state_nxt = S_HUNT;
      end
      default: state_nxt = S_HUNT;
    endcase
  end

  // Payload slot index, running checksum, inter-byte timer and frame buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      sum        <= '0;
      timer      <= '0;
      frame_data <= '0;
    end else begin
      if (state != S_PAYLOAD || abort) idx <= '0;
      else if (write_en)               idx <= last_slot ? '0 : idx + 1'b1;

      if (state == S_HUNT) sum <= '0;
      else if (write_en)   sum <= sum + dec_data;

      if (in_frame && !accept && !abort) timer <= timer + 1'b1;
      else                               timer <= '0;

      if (write_en) frame_data[int'(idx)*N_PKT +: N_PKT] <= dec_data;
    end
  end

  // Link-quality counters, at most one step per cycle each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_ct <= '0;
      bad_ct  <= '0;
    end else begin
      if (good_inc) good_ct <= sat_inc(good_ct);
      if (bad_inc)  bad_ct  <= sat_inc(bad_ct);
    end
  end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Bench for rx_frame_assembler: fixed vector table, hand sequences for the
// multi-cycle corners, and a randomized frame stream checked against a
// queue-based frame model.
module tb_rx_frame_assembler;

  localparam int          N_PKT   = 8;
  localparam int          PAYLOAD = 4;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int          TIMEOUT = 16;
  localparam int          TIMER_W = 24;
  localparam int          CNT_W   = 2;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N_PKT-1:0]         dec_data;
  logic                     dec_avail;
  logic                     dec_error;
  logic                     dec_read;
  logic [PAYLOAD*N_PKT-1:0] frame_data;
  logic                     frame_valid;
  logic                     frame_ready;
  logic [CNT_W-1:0]         good_ct;
  logic [CNT_W-1:0]         bad_ct;

  rx_frame_assembler #(
    .N_PKT(N_PKT), .PAYLOAD(PAYLOAD), .SYNC(SYNC),
    .TIMEOUT(TIMEOUT), .TIMER_W(TIMER_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_data(dec_data), .dec_avail(dec_avail), .dec_error(dec_error),
    .dec_read(dec_read), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .good_ct(good_ct), .bad_ct(bad_ct)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit         m_in;        // a SYNC has been seen, frame being collected
  bit         m_hold;      // completed good frame waiting for the sink
  logic [7:0] m_q[$];      // payload bytes collected so far
  logic [7:0] m_slot[PAYLOAD];
  int         m_idle;
  int         m_good;
  int         m_bad;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_in = 0; m_hold = 0; m_q.delete(); m_idle = 0; m_good = 0; m_bad = 0;
    for (int i = 0; i < PAYLOAD; i++) m_slot[i] = 8'h00;
  endtask

  task automatic model_abort();
    m_in = 0; m_bad = sat(m_bad);
  endtask

  task automatic model_step(input logic av, input logic [7:0] d, input logic er, input logic rdy);
    bit acc;
    int s;
    acc = av && !m_hold;
    if (m_hold) begin
      if (rdy) m_hold = 0;
    end else if (!m_in) begin
      if (acc && d == SYNC) begin m_in = 1; m_q.delete(); m_idle = 0; end
    end else if (er) begin
      model_abort();
    end else if (acc) begin
      m_idle = 0;
      if (m_q.size() < PAYLOAD) begin
        m_slot[m_q.size()] = d;
        m_q.push_back(d);
      end else begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        m_in = 0;
        if (int'(d) == s % 256) begin m_hold = 1; m_good = sat(m_good); end
        else m_bad = sat(m_bad);
      end
    end else begin
      m_idle++;
      if (m_idle >= TIMEOUT) model_abort();
    end
  endtask

  task automatic compare_model();
    logic [PAYLOAD*N_PKT-1:0] exp_data;
    for (int i = 0; i < PAYLOAD; i++) exp_data[i*8 +: 8] = m_slot[i];
    chk("frame_valid", frame_valid, m_hold);
    chk("dec_read", dec_read, !m_hold);
    chk("frame_data", frame_data, exp_data);
    chk("good_ct", good_ct, m_good);
    chk("bad_ct", bad_ct, m_bad);
  endtask

  // One clock: drive inputs at a falling edge, let the rising edge act, check at the next falling edge.
  task automatic step(input logic av, input logic [7:0] d, input logic er, input logic rdy);
    dec_avail = av; dec_data = d; dec_error = er; frame_ready = rdy;
    model_step(av, d, er, rdy);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    dec_avail = 0; dec_data = 0; dec_error = 0; frame_ready = 0;
    rst_n = 0;
    model_reset();
    #1;
    compare_model();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Offer a byte until consumed (bounded), with random sink readiness.
  task automatic send(input logic [7:0] b, input int err_pct);
    bit done;
    bit will;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      will = !m_hold;
      step(1'b1, b, ($urandom_range(99) < err_pct), 1'($urandom_range(1)));
      done = will;
    end
    if (!done) begin
      n_total++; n_bad++;
      $display("FAIL send_bound: byte %0h never consumed", b);
    end
  endtask

  task automatic gap(input int err_pct);
    int n;
    n = ($urandom_range(99) < 5) ? 20 : $urandom_range(3);
    repeat (n) step(1'b0, 8'($urandom), ($urandom_range(99) < err_pct), 1'($urandom_range(1)));
  endtask

  task automatic send_frame(input logic [7:0] p0, p1, p2, p3, ck);
    step(1, SYNC, 0, 0); step(1, p0, 0, 0); step(1, p1, 0, 0);
    step(1, p2, 0, 0);   step(1, p3, 0, 0); step(1, ck, 0, 0);
  endtask

  typedef struct {
    logic        av;
    logic [7:0]  d;
    logic        er;
    logic        rdy;
    logic        e_valid;
    logic        e_read;
    logic [31:0] e_data;
    logic [1:0]  e_good;
    logic [1:0]  e_bad;
  } vec_t;

  vec_t tbl[14];
  logic [31:0] held;

  initial begin
    // Bad-checksum frame, then a good frame, held and released.
    tbl[0]  = '{1, 8'hA5, 0, 0, 0, 1, 32'h00000000, 0, 0};
    tbl[1]  = '{1, 8'h01, 0, 0, 0, 1, 32'h00000001, 0, 0};
    tbl[2]  = '{1, 8'h02, 0, 0, 0, 1, 32'h00000201, 0, 0};
    tbl[3]  = '{1, 8'h03, 0, 0, 0, 1, 32'h00030201, 0, 0};
    tbl[4]  = '{1, 8'h04, 0, 0, 0, 1, 32'h04030201, 0, 0};
    tbl[5]  = '{1, 8'h0B, 0, 0, 0, 1, 32'h04030201, 0, 1};
    tbl[6]  = '{1, 8'hA5, 0, 0, 0, 1, 32'h04030201, 0, 1};
    tbl[7]  = '{1, 8'h01, 0, 0, 0, 1, 32'h04030201, 0, 1};
    tbl[8]  = '{1, 8'h02, 0, 0, 0, 1, 32'h04030201, 0, 1};
    tbl[9]  = '{1, 8'h03, 0, 0, 0, 1, 32'h04030201, 0, 1};
    tbl[10] = '{1, 8'h04, 0, 0, 0, 1, 32'h04030201, 0, 1};
    tbl[11] = '{1, 8'h0A, 0, 0, 1, 0, 32'h04030201, 1, 1};
    tbl[12] = '{1, 8'hFF, 0, 0, 1, 0, 32'h04030201, 1, 1};
    tbl[13] = '{0, 8'h00, 0, 1, 0, 1, 32'h04030201, 1, 1};

    rst_n = 0;
    dec_avail = 0; dec_data = 0; dec_error = 0; frame_ready = 0;
    @(negedge clk);
    do_reset();
    chk("reset_read", dec_read, 1'b1);
    chk("reset_data", frame_data, 32'h0);

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].av, tbl[i].d, tbl[i].er, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), frame_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_read", i), dec_read, tbl[i].e_read);
      chk($sformatf("tbl%0d_data", i), frame_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_good", i), good_ct, tbl[i].e_good);
      chk($sformatf("tbl%0d_bad", i), bad_ct, tbl[i].e_bad);
    end

    // Garbage before a frame, then a frame carrying SYNC values as data.
    step(1, 8'h00, 0, 0); step(1, 8'hFF, 0, 0); step(1, 8'h3C, 0, 0);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
    chk("garbage_valid", frame_valid, 1'b1);
    chk("garbage_data", frame_data, 32'h44332211);
    step(0, 8'h00, 0, 1);
    send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5);
    chk("syncdata_valid", frame_valid, 1'b1);
    chk("syncdata_data", frame_data, 32'h000000A5);

    // Back-pressure: sink not ready for 20 cycles while decoder offers a byte.
    held = frame_data;
    for (int i = 0; i < 20; i++) begin
      step(1, 8'h77, 0, 0);
      chk("hold_read", dec_read, 1'b0);
      chk("hold_data", frame_data, held);
    end
    step(1, 8'h77, 0, 1);
    chk("release_valid", frame_valid, 1'b0);
    chk("release_read", dec_read, 1'b1);

    // Decoder error mid-frame, then inter-byte timeout.
    do_reset();
    step(1, SYNC, 0, 0); step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0);
    step(1, 8'h03, 1, 0);
    chk("err_bad", bad_ct, 2'd1);
    step(1, SYNC, 0, 0); step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0);
    repeat (15) step(0, 8'h00, 0, 0);
    chk("tmo15_bad", bad_ct, 2'd1);
    step(0, 8'h00, 0, 0);
    chk("tmo16_bad", bad_ct, 2'd2);
    // Accept on the would-be timeout cycle keeps the frame alive.
    step(1, SYNC, 0, 0); step(1, 8'h01, 0, 0);
    repeat (15) step(0, 8'h00, 0, 0);
    step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0); step(1, 8'h04, 0, 0);
    step(1, 8'h0A, 0, 0);
    chk("tmo_race_bad", bad_ct, 2'd2);
    chk("tmo_race_valid", frame_valid, 1'b1);
    step(0, 8'h00, 0, 1);

    // Reset in the middle of a frame, then counter saturation.
    do_reset();
    step(1, SYNC, 0, 0); step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0);
    do_reset();
    chk("midrst_data", frame_data, 32'h0);
    chk("midrst_bad", bad_ct, 2'd0);
    chk("midrst_valid", frame_valid, 1'b0);
    repeat (5) send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    chk("sat_bad", bad_ct, 2'd3);

    // Randomized frame stream with gaps, errors, corrupt checksums and back-pressure.
    do_reset();
    for (int f = 0; f < 300; f++) begin
      logic [7:0] s;
      logic [7:0] b;
      repeat ($urandom_range(2)) send(8'($urandom), 2);
      send(SYNC, 2);
      s = 8'h00;
      for (int i = 0; i < PAYLOAD; i++) begin
        b = ($urandom_range(9) == 0) ? SYNC : 8'($urandom);
        s = s + b;
        gap(2);
        send(b, 2);
      end
      gap(2);
      send(($urandom_range(99) < 80) ? s : s + 8'h01, 2);
    end
    repeat (4) step(0, 8'h00, 0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
